// File: rtl/accum_cpu_core.sv
// Accumulator CPU core: 16-bit instructions, one memory port with req/ack handshake.
// Memory-side outputs are decoded from the current state, so a request is held steady until acked.
//
// state      | meaning
// -----------+--------------------------------------------------------------
// S_FETCH    | read instruction at pc, then advance pc by 2
// S_DECODE   | execute register/branch ops, or pick the memory path
// S_MEM_PTR  | read pointer word at operand (indirect ops)
// S_MEM_DATA | data read/write at operand (direct) or ptr (indirect)
// S_HALT     | stopped until reset, no memory traffic
module accum_cpu_core #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 16,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC = 'h100
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_ack,
    output logic [ADDR_WIDTH-1:0] pc,
    output logic [DATA_WIDTH-1:0] ac,
    output logic [15:0]           ir,
    output logic                  halted
);

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_MEM_PTR,
        S_MEM_DATA,
        S_HALT
    } state_t;

    localparam logic [3:0] OP_NOP   = 4'h0;
    localparam logic [3:0] OP_LOAD  = 4'h1;
    localparam logic [3:0] OP_STORE = 4'h2;
    localparam logic [3:0] OP_CLEAR = 4'h3;
    localparam logic [3:0] OP_SKIP  = 4'h4;
    localparam logic [3:0] OP_JUMP  = 4'h5;
    localparam logic [3:0] OP_HALT  = 4'h6;
    localparam logic [3:0] OP_ADD   = 4'h7;
    localparam logic [3:0] OP_SUB   = 4'h8;
    localparam logic [3:0] OP_AND   = 4'h9;
    localparam logic [3:0] OP_OR    = 4'hA;
    localparam logic [3:0] OP_NOT   = 4'hB;
    localparam logic [3:0] OP_LDI   = 4'hC;
    localparam logic [3:0] OP_STI   = 4'hD;
    localparam logic [3:0] OP_ADDI  = 4'hE;
    localparam logic [3:0] OP_JMPI  = 4'hF;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [DATA_WIDTH-1:0] ac_q, ac_d;
    logic [15:0]           ir_q, ir_d;
    logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;

    logic [3:0]            opcode;
    logic [ADDR_WIDTH-1:0] operand;
    logic [ADDR_WIDTH-1:0] pc_plus2;
    logic                  is_indirect;
    logic                  is_store;
    logic                  ac_neg;
    logic                  ac_zero;
    logic                  skip;

    assign opcode      = ir_q[15:12];
    assign operand     = ADDR_WIDTH'(ir_q[11:0]);
    assign pc_plus2    = pc_q + ADDR_WIDTH'(2);
    assign is_indirect = opcode[3] & opcode[2];
    assign is_store    = (opcode == OP_STORE) || (opcode == OP_STI);
    assign ac_neg      = ac_q[DATA_WIDTH-1];
    assign ac_zero     = (ac_q == '0);

    always_comb begin
        skip = 1'b0;
        case (ir_q[1:0])
            2'b00:   skip = ac_neg;
            2'b01:   skip = ac_zero;
            2'b10:   skip = !ac_neg && !ac_zero;
            default: skip = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
            pc_q    <= RESET_PC;
            ac_q    <= '0;
            ir_q    <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ac_q    <= ac_d;
            ir_q    <= ir_d;
            ptr_q   <= ptr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ac_d      = ac_q;
        ir_d      = ir_q;
        ptr_d     = ptr_q;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;

        case (state_q)
            S_FETCH: begin
                mem_req  = 1'b1;
                mem_addr = pc_q;
                if (mem_ack) begin
                    ir_d    = mem_rdata[15:0];
                    pc_d    = pc_plus2;
                    state_d = S_DECODE;
                end
            end

            S_DECODE: begin
                state_d = S_FETCH;
                case (opcode)
                    OP_NOP:   ;
                    OP_CLEAR: ac_d = '0;
                    OP_SKIP:  if (skip) pc_d = pc_plus2;
                    OP_JUMP:  pc_d = operand;
                    OP_HALT:  state_d = S_HALT;
                    OP_NOT:   ac_d = ~ac_q;
                    OP_LOAD, OP_STORE, OP_ADD, OP_SUB, OP_AND, OP_OR:
                              state_d = S_MEM_DATA;
                    default:  state_d = S_MEM_PTR;
                endcase
            end

            S_MEM_PTR: begin
                mem_req  = 1'b1;
                mem_addr = operand;
                if (mem_ack) begin
                    ptr_d = mem_rdata[ADDR_WIDTH-1:0];
                    // Jump-indirect takes the pointer straight from the bus; no data phase follows.
                    if (opcode == OP_JMPI) begin
                        pc_d    = mem_rdata[ADDR_WIDTH-1:0];
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_MEM_DATA;
                    end
                end
            end

            S_MEM_DATA: begin
                mem_req  = 1'b1;
                mem_addr = is_indirect ? ptr_q : operand;
                if (is_store) begin
                    mem_we    = 1'b1;
                    mem_wdata = ac_q;
                end
                if (mem_ack) begin
                    state_d = S_FETCH;
                    case (opcode)
                        OP_LOAD, OP_LDI: ac_d = mem_rdata;
                        OP_ADD, OP_ADDI: ac_d = ac_q + mem_rdata;
                        OP_SUB:          ac_d = ac_q - mem_rdata;
                        OP_AND:          ac_d = ac_q & mem_rdata;
                        OP_OR:           ac_d = ac_q | mem_rdata;
                        default:         ac_d = ac_q;
                    endcase
                end
            end

            S_HALT: ;

            default: state_d = S_FETCH;
        endcase

        // An asserted reset drops any in-flight request immediately.
        if (rst) begin
            mem_req   = 1'b0;
            mem_we    = 1'b0;
            mem_addr  = '0;
            mem_wdata = '0;
        end
    end

    assign pc     = pc_q;
    assign ac     = ac_q;
    assign ir     = ir_q;
    assign halted = (state_q == S_HALT);

endmodule
